// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg -- shared FSM encodings, register/source indices, ctrl struct
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_FWD_SRCS = 3;
  localparam int DEF_MD_LAT   = 4;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  localparam int REG_ZERO = 0;

  localparam int SRC_EX  = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_WB  = 2;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic md_busy;
    logic md_done;
  } hz_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if -- pipeline <-> hazard controller bus (master = pipeline)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FWD_SRCS = DEF_FWD_SRCS
);

  logic [ADDR_W-1:0]          id_raddr1;
  logic [ADDR_W-1:0]          id_raddr2;
  logic                       id_rd_en1;
  logic                       id_rd_en2;
  logic [DATA_W-1:0]          rf_rdata1;
  logic [DATA_W-1:0]          rf_rdata2;
  logic [FWD_SRCS*ADDR_W-1:0] src_waddr;
  logic [FWD_SRCS-1:0]        src_we;
  logic [FWD_SRCS*DATA_W-1:0] src_data;
  logic [FWD_SRCS-1:0]        src_is_load;
  logic                       ex_md_start;
  logic                       id_branch_taken;

  logic [DATA_W-1:0]          id_rdata1;
  logic [DATA_W-1:0]          id_rdata2;
  logic                       pc_stall;
  logic                       if_id_stall;
  logic                       id_ex_stall;
  logic                       id_ex_bubble;
  logic                       ex_mem_bubble;
  logic                       if_id_flush;
  logic                       md_busy;
  logic                       md_done;

  modport master (
    output id_raddr1, id_raddr2, id_rd_en1, id_rd_en2, rf_rdata1, rf_rdata2,
           src_waddr, src_we, src_data, src_is_load, ex_md_start, id_branch_taken,
    input  id_rdata1, id_rdata2, pc_stall, if_id_stall, id_ex_stall,
           id_ex_bubble, ex_mem_bubble, if_id_flush, md_busy, md_done
  );

  modport slave (
    input  id_raddr1, id_raddr2, id_rd_en1, id_rd_en2, rf_rdata1, rf_rdata2,
           src_waddr, src_we, src_data, src_is_load, ex_md_start, id_branch_taken,
    output id_rdata1, id_rdata2, pc_stall, if_id_stall, id_ex_stall,
           id_ex_bubble, ex_mem_bubble, if_id_flush, md_busy, md_done
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_mux.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_fwd_mux -- priority operand forwarding for one ID source operand
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl_fwd_mux
  import hazard_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FWD_SRCS = DEF_FWD_SRCS
) (
  input  wire logic [ADDR_W-1:0]          raddr_i,
  input  wire logic [DATA_W-1:0]          rf_rdata_i,
  input  wire logic [FWD_SRCS*ADDR_W-1:0] src_waddr_i,
  input  wire logic [FWD_SRCS-1:0]        src_we_i,
  input  wire logic [FWD_SRCS*DATA_W-1:0] src_data_i,
  input  wire logic                       src_is_load0_i,
  output logic      [DATA_W-1:0]          rdata_o
);

  // Walk oldest to youngest so the lowest matching index wins; a load in EX
  // has no data yet and must never be forwarded.
  always_comb begin
    rdata_o = rf_rdata_i;
    for (int i = FWD_SRCS - 1; i >= 0; i--) begin
      if (src_we_i[i] && (src_waddr_i[i*ADDR_W +: ADDR_W] == raddr_i) &&
          !((i == SRC_EX) && src_is_load0_i)) begin
        rdata_o = src_data_i[i*DATA_W +: DATA_W];
      end
    end
    if (raddr_i == ADDR_W'(REG_ZERO)) begin
      rdata_o = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- forwarding, load-use, mul/div stall FSM and branch flush
// Rev 1.0 -- optional perf counters via HAZARD_PERF_CNT_EN
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FWD_SRCS = DEF_FWD_SRCS,
  parameter int MD_LAT   = DEF_MD_LAT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  hazard_ctrl_if.slave      bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic      [31:0]  perf_stall_cnt,
  output logic      [31:0]  perf_flush_cnt
`endif
);

  localparam logic [3:0] MD_RELOAD = (MD_LAT >= 2) ? 4'(MD_LAT - 2) : 4'd0;

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_stall;
  logic       lu_hit;
  logic       load_use;
  hz_ctrl_t   ctrl;
  hz_ctrl_t   ctrl_gated;
  logic       unused_load_flags;

  logic [ADDR_W-1:0] ex_waddr;

  assign ex_waddr          = bus.src_waddr[SRC_EX*ADDR_W +: ADDR_W];
  assign unused_load_flags = ^bus.src_is_load;

  hazard_ctrl_fwd_mux #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .FWD_SRCS (FWD_SRCS)
  ) u_fwd1 (
    .raddr_i        (bus.id_raddr1),
    .rf_rdata_i     (bus.rf_rdata1),
    .src_waddr_i    (bus.src_waddr),
    .src_we_i       (bus.src_we),
    .src_data_i     (bus.src_data),
    .src_is_load0_i (bus.src_is_load[SRC_EX]),
    .rdata_o        (bus.id_rdata1)
  );

  hazard_ctrl_fwd_mux #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .FWD_SRCS (FWD_SRCS)
  ) u_fwd2 (
    .raddr_i        (bus.id_raddr2),
    .rf_rdata_i     (bus.rf_rdata2),
    .src_waddr_i    (bus.src_waddr),
    .src_we_i       (bus.src_we),
    .src_data_i     (bus.src_data),
    .src_is_load0_i (bus.src_is_load[SRC_EX]),
    .rdata_o        (bus.id_rdata2)
  );

  // The held mul/div op keeps ex_md_start high while waiting, so it is only
  // acted on from RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    ctrl     = '0;
    case (state_q)
      ST_RUN: begin
        if (bus.ex_md_start) begin
          if (MD_LAT == 1) begin
            ctrl.md_done = 1'b1;
          end else begin
            md_stall = 1'b1;
            cnt_d    = MD_RELOAD;
            state_d  = ST_MD_WAIT;
          end
        end
      end
      ST_MD_WAIT: begin
        ctrl.md_busy = 1'b1;
        if (cnt_q != 4'd0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          ctrl.md_done = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase

    lu_hit = bus.src_we[SRC_EX] && bus.src_is_load[SRC_EX] &&
             (ex_waddr != ADDR_W'(REG_ZERO)) &&
             ((bus.id_rd_en1 && (bus.id_raddr1 == ex_waddr)) ||
              (bus.id_rd_en2 && (bus.id_raddr2 == ex_waddr)));
    load_use = (state_q == ST_RUN) && !md_stall && lu_hit;

    ctrl.pc_stall      = md_stall || load_use;
    ctrl.if_id_stall   = md_stall || load_use;
    ctrl.id_ex_stall   = md_stall;
    ctrl.id_ex_bubble  = load_use;
    ctrl.ex_mem_bubble = md_stall;
    ctrl.if_id_flush   = bus.id_branch_taken && !ctrl.if_id_stall;
  end

  // Control outputs are forced quiet for as long as reset is held.
  assign ctrl_gated = rst ? ctrl : '0;

  assign bus.pc_stall      = ctrl_gated.pc_stall;
  assign bus.if_id_stall   = ctrl_gated.if_id_stall;
  assign bus.id_ex_stall   = ctrl_gated.id_ex_stall;
  assign bus.id_ex_bubble  = ctrl_gated.id_ex_bubble;
  assign bus.ex_mem_bubble = ctrl_gated.ex_mem_bubble;
  assign bus.if_id_flush   = ctrl_gated.if_id_flush;
  assign bus.md_busy       = ctrl_gated.md_busy;
  assign bus.md_done       = ctrl_gated.md_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (ctrl_gated.pc_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (ctrl_gated.if_id_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire
